ex_operand_stage: RTL and testbench

ID/EX pipeline register plus operand-forwarding and ALU-control decode for the 64-bit RISC-V pipeline. Drives the ALU's X, Y and 4-bit aluControl inputs directly. Also detects load-use hazards and inserts bubbles, and accepts branch flushes. One clock; registered state, combinational forwarding.

---
 rtl/ex_operand_stage_if.sv | 51 +++++
 rtl/ex_operand_stage.sv | 120 ++++++++++++
 tb/tb_ex_operand_stage.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_if.sv
// Bundles the ID-stage operands, the forwarding sources and the EX-stage
// outputs that connect ex_operand_stage to the rest of the pipeline.
interface ex_operand_stage_if #(
   parameter int XLEN = 64,
   parameter int REGW = 5
);
   logic            id_valid;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [XLEN-1:0] id_imm;
   logic [REGW-1:0] id_rs1;
   logic [REGW-1:0] id_rs2;
   logic [REGW-1:0] id_rd;
   logic            id_alu_src;
   logic [1:0]      id_alu_op;
   logic [3:0]      id_funct;
   logic [4:0]      id_ctrl;
   logic            flush;
   logic            exmem_reg_write;
   logic            memwb_reg_write;
   logic [REGW-1:0] exmem_rd;
   logic [REGW-1:0] memwb_rd;
   logic [XLEN-1:0] exmem_result;
   logic [XLEN-1:0] memwb_result;
   logic [XLEN-1:0] alu_x;
   logic [XLEN-1:0] alu_y;
   logic [3:0]      alu_control;
   logic [XLEN-1:0] ex_store_data;
   logic [REGW-1:0] ex_rd;
   logic [4:0]      ex_ctrl;
   logic            ex_valid;
   logic            stall;

   modport master (
      output id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
             id_alu_src, id_alu_op, id_funct, id_ctrl, flush,
             exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
             exmem_result, memwb_result,
      input  alu_x, alu_y, alu_control, ex_store_data, ex_rd, ex_ctrl,
             ex_valid, stall
   );

   modport slave (
      input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
             id_alu_src, id_alu_op, id_funct, id_ctrl, flush,
             exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
             exmem_result, memwb_result,
      output alu_x, alu_y, alu_control, ex_store_data, ex_rd, ex_ctrl,
             ex_valid, stall
   );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with ALU-control decode, load-use stall detection
// and combinational EX/MEM, MEM/WB operand forwarding.
module ex_operand_stage #(
   parameter int XLEN = 64,
   parameter int REGW = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   ex_operand_stage_if.slave  bus
);
   localparam logic [3:0] ALU_AND  = 4'h0;
   localparam logic [3:0] ALU_OR   = 4'h1;
   localparam logic [3:0] ALU_ADD  = 4'h2;
   localparam logic [3:0] ALU_SUB  = 4'h6;
   localparam logic [3:0] ALU_ZERO = 4'hF;

   localparam int CTRL_MEM_READ = 3;

   logic            ex_valid_q;
   logic [4:0]      ex_ctrl_q;
   logic [REGW-1:0] ex_rd_q;
   logic [REGW-1:0] ex_rs1_q;
   logic [REGW-1:0] ex_rs2_q;
   logic [XLEN-1:0] ex_rs1_data_q;
   logic [XLEN-1:0] ex_rs2_data_q;
   logic [XLEN-1:0] ex_imm_q;
   logic            ex_alu_src_q;
   logic [3:0]      alu_control_q;

   logic            hazard;
   logic            bubble;
   logic [3:0]      alu_control_d;
   logic [XLEN-1:0] fwd_a;
   logic [XLEN-1:0] fwd_b;

   function automatic logic [3:0] decode_alu(input logic [1:0] op, input logic [3:0] funct);
      logic [3:0] code;
      code = ALU_ZERO;
      case (op)
         2'b00: code = ALU_ADD;
         2'b01: code = ALU_SUB;
         2'b10: begin
            case (funct)
               4'b0000: code = ALU_ADD;
               4'b1000: code = ALU_SUB;
               4'b0111: code = ALU_AND;
               4'b0110: code = ALU_OR;
               default: code = ALU_ZERO;
            endcase
         end
         default: code = ALU_ZERO;
      endcase
      return code;
   endfunction

   always_comb begin
      hazard = ex_valid_q & ex_ctrl_q[CTRL_MEM_READ] & (ex_rd_q != '0) & bus.id_valid &
               ((ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2));
      bubble = bus.flush | hazard | ~bus.id_valid;
      alu_control_d = decode_alu(bus.id_alu_op, bus.id_funct);
   end

   // Data registers follow ID even during a bubble; only the control side is killed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid_q    <= 1'b0;
         ex_ctrl_q     <= '0;
         ex_rd_q       <= '0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_rs1_data_q <= '0;
         ex_rs2_data_q <= '0;
         ex_imm_q      <= '0;
         ex_alu_src_q  <= 1'b0;
         alu_control_q <= ALU_ZERO;
      end else begin
         ex_rs1_q      <= bus.id_rs1;
         ex_rs2_q      <= bus.id_rs2;
         ex_rs1_data_q <= bus.id_rs1_data;
         ex_rs2_data_q <= bus.id_rs2_data;
         ex_imm_q      <= bus.id_imm;
         ex_alu_src_q  <= bus.id_alu_src;
         if (bubble) begin
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= '0;
            ex_rd_q       <= '0;
            alu_control_q <= ALU_ZERO;
         end else begin
            ex_valid_q    <= 1'b1;
            ex_ctrl_q     <= bus.id_ctrl;
            ex_rd_q       <= bus.id_rd;
            alu_control_q <= alu_control_d;
         end
      end
   end

   // EX/MEM is the younger result, so it wins over MEM/WB; x0 is never forwarded.
   always_comb begin
      fwd_a = ex_rs1_data_q;
      if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_rs1_q))
         fwd_a = bus.exmem_result;
      else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_rs1_q))
         fwd_a = bus.memwb_result;

      fwd_b = ex_rs2_data_q;
      if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_rs2_q))
         fwd_b = bus.exmem_result;
      else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_rs2_q))
         fwd_b = bus.memwb_result;
   end

   assign bus.alu_x         = fwd_a;
   assign bus.alu_y         = ex_alu_src_q ? ex_imm_q : fwd_b;
   assign bus.ex_store_data = fwd_b;
   assign bus.alu_control   = alu_control_q;
   assign bus.ex_rd         = ex_rd_q;
   assign bus.ex_ctrl       = ex_ctrl_q;
   assign bus.ex_valid      = ex_valid_q;
   assign bus.stall         = hazard;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: one task per feature, inline checks.
module tb_ex_operand_stage;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   ex_operand_stage_if #(.XLEN(64), .REGW(5)) bus ();

   ex_operand_stage #(.XLEN(64), .REGW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.id_valid        = 1'b0;
      bus.id_rs1_data     = '0;
      bus.id_rs2_data     = '0;
      bus.id_imm          = '0;
      bus.id_rs1          = '0;
      bus.id_rs2          = '0;
      bus.id_rd           = '0;
      bus.id_alu_src      = 1'b0;
      bus.id_alu_op       = 2'b00;
      bus.id_funct        = 4'b0000;
      bus.id_ctrl         = '0;
      bus.flush           = 1'b0;
      bus.exmem_reg_write = 1'b0;
      bus.memwb_reg_write = 1'b0;
      bus.exmem_rd        = '0;
      bus.memwb_rd        = '0;
      bus.exmem_result    = '0;
      bus.memwb_result    = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      bus.id_valid    = 1'b1;
      bus.id_rs1_data = 64'h1234;
      bus.id_rs2_data = 64'h5678;
      bus.id_rd       = 5'd4;
      bus.id_ctrl     = 5'b01011;
      step();
      step();
      checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", bus.ex_valid); end
      checks++; if (bus.alu_control !== 4'hF) begin failures++; $display("FAIL reset_aluctl got=%0h exp=f", bus.alu_control); end
      checks++; if (bus.alu_x !== 64'h0) begin failures++; $display("FAIL reset_alu_x got=%0h exp=0", bus.alu_x); end
      checks++; if (bus.alu_y !== 64'h0) begin failures++; $display("FAIL reset_alu_y got=%0h exp=0", bus.alu_y); end
      checks++; if (bus.ex_ctrl !== 5'h0 || bus.ex_rd !== 5'h0) begin failures++; $display("FAIL reset_ctrl_rd got=%0h/%0h exp=0/0", bus.ex_ctrl, bus.ex_rd); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", bus.stall); end
      rst_n = 1'b1;
   endtask

   task automatic test_rtype_and();
      clear_inputs();
      bus.id_valid    = 1'b1;
      bus.id_rs1      = 5'd1;
      bus.id_rs2      = 5'd2;
      bus.id_rd       = 5'd3;
      bus.id_rs1_data = 64'hF0;
      bus.id_rs2_data = 64'h3C;
      bus.id_alu_op   = 2'b10;
      bus.id_funct    = 4'b0111;
      bus.id_ctrl     = 5'b00010;
      step();
      bus.id_valid = 1'b0;
      checks++; if (bus.alu_control !== 4'h0) begin failures++; $display("FAIL and_aluctl got=%0h exp=0", bus.alu_control); end
      checks++; if (bus.alu_x !== 64'hF0) begin failures++; $display("FAIL and_alu_x got=%0h exp=f0", bus.alu_x); end
      checks++; if (bus.alu_y !== 64'h3C) begin failures++; $display("FAIL and_alu_y got=%0h exp=3c", bus.alu_y); end
      checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL and_valid got=%0h exp=1", bus.ex_valid); end
      checks++; if (bus.ex_rd !== 5'd3 || bus.ex_ctrl !== 5'b00010) begin failures++; $display("FAIL and_rd_ctrl got=%0h/%0h exp=3/2", bus.ex_rd, bus.ex_ctrl); end
   endtask

   task automatic test_decode();
      logic [1:0] ops   [8] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
      logic [3:0] fns   [8] = '{4'b1000, 4'b0111, 4'b0000, 4'b1000, 4'b0110, 4'b0001, 4'b1111, 4'b0000};
      logic [3:0] codes [8] = '{4'h2, 4'h6, 4'h2, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF};
      clear_inputs();
      for (int i = 0; i < 8; i++) begin
         bus.id_valid  = 1'b1;
         bus.id_alu_op = ops[i];
         bus.id_funct  = fns[i];
         step();
         checks++;
         if (bus.alu_control !== codes[i]) begin
            failures++;
            $display("FAIL decode_%0d op=%b funct=%b got=%0h exp=%0h", i, ops[i], fns[i], bus.alu_control, codes[i]);
         end
      end
   endtask

   task automatic test_forward();
      clear_inputs();
      bus.id_valid    = 1'b1;
      bus.id_rs1      = 5'd5;
      bus.id_rs2      = 5'd6;
      bus.id_rd       = 5'd10;
      bus.id_rs1_data = 64'hAA;
      bus.id_rs2_data = 64'hBB;
      step();
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 64'h11;
      bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 64'h22;
      #1;
      checks++; if (bus.alu_x !== 64'h11) begin failures++; $display("FAIL fwd_exmem got=%0h exp=11", bus.alu_x); end
      checks++; if (bus.alu_y !== 64'hBB) begin failures++; $display("FAIL fwd_b_none got=%0h exp=bb", bus.alu_y); end
      bus.exmem_reg_write = 1'b0;
      #1;
      checks++; if (bus.alu_x !== 64'h22) begin failures++; $display("FAIL fwd_memwb got=%0h exp=22", bus.alu_x); end
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.memwb_rd = 5'd0;
      #1;
      checks++; if (bus.alu_x !== 64'hAA) begin failures++; $display("FAIL fwd_x0 got=%0h exp=aa", bus.alu_x); end
      bus.memwb_rd = 5'd6;
      #1;
      checks++; if (bus.alu_y !== 64'h22 || bus.ex_store_data !== 64'h22) begin failures++; $display("FAIL fwd_b_memwb got=%0h/%0h exp=22/22", bus.alu_y, bus.ex_store_data); end
      bus.exmem_rd = 5'd6;
      #1;
      checks++; if (bus.alu_y !== 64'h11) begin failures++; $display("FAIL fwd_b_exmem got=%0h exp=11", bus.alu_y); end
   endtask

   task automatic test_load_use();
      clear_inputs();
      bus.id_valid = 1'b1;
      bus.id_rd    = 5'd7;
      bus.id_ctrl  = 5'b01011;
      step();
      bus.id_rs1  = 5'd1;
      bus.id_rs2  = 5'd7;
      bus.id_rd   = 5'd8;
      bus.id_ctrl = 5'b00010;
      #1;
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0h exp=1", bus.stall); end
      bus.id_valid = 1'b0;
      #1;
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL lu_idinvalid got=%0h exp=0", bus.stall); end
      bus.id_valid = 1'b1;
      step();
      checks++; if (bus.ex_valid !== 1'b0 || bus.stall !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%0h/%0h exp=0/0", bus.ex_valid, bus.stall); end
      checks++; if (bus.alu_control !== 4'hF || bus.ex_ctrl !== 5'h0) begin failures++; $display("FAIL lu_bubble_ctrl got=%0h/%0h exp=f/0", bus.alu_control, bus.ex_ctrl); end
      step();
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd8) begin failures++; $display("FAIL lu_replay got=%0h/%0h exp=1/8", bus.ex_valid, bus.ex_rd); end
      // load into x0 never stalls
      bus.id_rd   = 5'd0;
      bus.id_ctrl = 5'b01000;
      step();
      bus.id_rs1 = 5'd0;
      #1;
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL lu_x0 got=%0h exp=0", bus.stall); end
   endtask

   task automatic test_flush();
      clear_inputs();
      bus.id_valid = 1'b1;
      bus.id_rd    = 5'd9;
      bus.id_ctrl  = 5'b00010;
      bus.flush    = 1'b1;
      step();
      checks++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 5'h0) begin failures++; $display("FAIL flush_valid_ctrl got=%0h/%0h exp=0/0", bus.ex_valid, bus.ex_ctrl); end
      checks++; if (bus.alu_control !== 4'hF || bus.ex_rd !== 5'd0) begin failures++; $display("FAIL flush_aluctl_rd got=%0h/%0h exp=f/0", bus.alu_control, bus.ex_rd); end
      // flush coinciding with a load-use hazard
      bus.flush   = 1'b0;
      bus.id_rd   = 5'd12;
      bus.id_ctrl = 5'b01011;
      step();
      bus.flush  = 1'b1;
      bus.id_rs1 = 5'd12;
      bus.id_rd  = 5'd13;
      #1;
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL flush_stall got=%0h exp=1", bus.stall); end
      step();
      checks++; if (bus.ex_valid !== 1'b0 || bus.stall !== 1'b0) begin failures++; $display("FAIL flush_stall_bubble got=%0h/%0h exp=0/0", bus.ex_valid, bus.stall); end
   endtask

   task automatic test_itype();
      clear_inputs();
      bus.id_valid    = 1'b1;
      bus.id_rs1      = 5'd3;
      bus.id_rs2      = 5'd9;
      bus.id_rd       = 5'd4;
      bus.id_rs2_data = 64'h55;
      bus.id_imm      = 64'hFFFF_FFFF_FFFF_FFFC;
      bus.id_alu_src  = 1'b1;
      bus.id_alu_op   = 2'b00;
      step();
      bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd9; bus.memwb_result = 64'h77;
      #1;
      checks++; if (bus.alu_y !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL itype_alu_y got=%0h exp=fffffffffffffffc", bus.alu_y); end
      checks++; if (bus.alu_control !== 4'h2) begin failures++; $display("FAIL itype_aluctl got=%0h exp=2", bus.alu_control); end
      checks++; if (bus.ex_store_data !== 64'h77) begin failures++; $display("FAIL itype_store got=%0h exp=77", bus.ex_store_data); end
   endtask

   task automatic test_reset_inflight();
      clear_inputs();
      bus.id_valid = 1'b1;
      bus.id_rd    = 5'd6;
      bus.id_ctrl  = 5'b00010;
      step();
      rst_n     = 1'b0;
      bus.flush = 1'b1;
      step();
      checks++; if (bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd0 || bus.alu_control !== 4'hF) begin failures++; $display("FAIL reset_inflight got=%0h/%0h/%0h exp=0/0/f", bus.ex_valid, bus.ex_rd, bus.alu_control); end
      rst_n     = 1'b1;
      bus.flush = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      clear_inputs();
      test_reset();
      test_rtype_and();
      test_decode();
      test_forward();
      test_load_use();
      test_flush();
      test_itype();
      test_reset_inflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
